uart_tx_sched: RTL and testbench

Two-requester transmit scheduler in front of `uart_tx` on the 3.125 MHz domain. Each requester pushes bytes, each tagged with its own parity type, into a private FIFO. A round-robin arbiter picks the next byte, pulses `tx_start` to `uart_tx`, waits for `tx_done`, and reports per-requester completion. A watchdog recovers from a missing `tx_done`.

---
 rtl/uart_sched_pkg.sv | 29 ++
 rtl/uart_byte_fifo.sv | 65 ++++++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler.
//   sched_state_t : scheduler FSM states (IDLE, START, WAIT)
//   CLKS_PER_BIT, FRAME_BITS, FRAME_CYCLES : nominal uart_tx frame timing
//   ENTRY_W       : requester FIFO entry width, {parity, data}
//   rr_pick       : round-robin choice between the two requester FIFOs
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int CLKS_PER_BIT = 14;
    localparam int FRAME_BITS   = 11;
    localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int ENTRY_W      = 9;

    // Returns the requester to serve. With both FIFOs holding data, the one
    // that did not win last time goes next; otherwise whichever has data.
    function automatic logic rr_pick(input logic ne0, input logic ne1,
                                     input logic last_grant);
        if (ne0 && ne1) begin
            return ~last_grant;
        end
        return ne1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO holding tagged bytes for one requester.
// Ports:
//   clk_3125  : clock, all state on posedge
//   rst       : asynchronous active-high reset, empties the FIFO
//   push      : write request; ignored while full
//   push_data : entry to write
//   pop       : read request; ignored while empty
//   pop_data  : current head entry (valid while !empty)
//   full      : DEPTH entries stored
//   empty     : no entries stored
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_3125,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: empty guards every read.
    always_ff @(posedge clk_3125) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester transmit scheduler in front of uart_tx.
// Each requester pushes {parity, data} into a private FIFO. A round-robin
// arbiter pops one entry, pulses tx_start, waits for tx_done and pulses the
// owning requester's done. A watchdog aborts a frame whose tx_done never
// arrives.
// Handshake: a byte is transferred on a rising clk_3125 edge where
// reqN_valid && reqN_ready; reqN_ready depends only on FIFO fullness and rst,
// never on reqN_valid, and is held low while rst is high.
// Ports:
//   clk_3125, rst                  : clock, async active-high reset
//   reqN_valid/data/parity/ready   : requester N push interface (N = 0, 1)
//   tx_start, tx_data, tx_parity_type : to uart_tx
//   tx_done                        : frame-complete pulse from uart_tx
//   done0, done1                   : per-requester completion pulses
//   tx_timeout                     : watchdog abort pulse
//   busy                           : high in START and WAIT
//   grant_id                       : requester owning the current frame
//   fsm_state                      : current scheduler state (debug)
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_parity,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_parity,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       tx_parity_type,
    input  logic       tx_done,
    output logic       done0,
    output logic       done1,
    output logic       tx_timeout,
    output logic       busy,
    output logic       grant_id,
    output logic [1:0] fsm_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t       state_q, state_d;
    logic [ENTRY_W-1:0] head0, head1;
    logic               full0, empty0, full1, empty1;
    logic               push0, push1, pop0, pop1;
    logic               sel;
    logic               grant_any;
    logic               last_grant_q;
    logic [WD_W-1:0]    wdog_q;
    logic               wd_expire;
    logic [7:0]         tx_data_q;
    logic               tx_par_q;
    logic               grant_q;
    logic               done0_q, done1_q, tmo_q;

    assign req0_ready = !full0 && !rst;
    assign req1_ready = !full1 && !rst;
    assign push0      = req0_valid && req0_ready;
    assign push1      = req1_valid && req1_ready;

    uart_byte_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo0 (
        .clk_3125  (clk_3125),
        .rst       (rst),
        .push      (push0),
        .push_data ({req0_parity, req0_data}),
        .pop       (pop0),
        .pop_data  (head0),
        .full      (full0),
        .empty     (empty0)
    );

    uart_byte_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo1 (
        .clk_3125  (clk_3125),
        .rst       (rst),
        .push      (push1),
        .push_data ({req1_parity, req1_data}),
        .pop       (pop1),
        .pop_data  (head1),
        .full      (full1),
        .empty     (empty1)
    );

    assign grant_any = !empty0 || !empty1;
    assign sel       = rr_pick(!empty0, !empty1, last_grant_q);
    // Watchdog reads k-1 in the k-th WAIT cycle, so this fires in the
    // TIMEOUT-th WAIT cycle.
    assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    pop0    = !sel;
                    pop1    = sel;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (tx_done || wd_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_par_q     <= 1'b0;
            wdog_q       <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_any) begin
                {tx_par_q, tx_data_q} <= sel ? head1 : head0;
                grant_q               <= sel;
                last_grant_q          <= sel;
            end
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end
            // tx_done wins over a simultaneous watchdog expiry.
            done0_q <= (state_q == WAIT) && tx_done && !grant_q;
            done1_q <= (state_q == WAIT) && tx_done && grant_q;
            tmo_q   <= (state_q == WAIT) && !tx_done && wd_expire;
        end
    end

    assign tx_start       = (state_q == START);
    assign busy           = (state_q != IDLE);
    assign tx_data        = tx_data_q;
    assign tx_parity_type = tx_par_q;
    assign grant_id       = grant_q;
    assign done0          = done0_q;
    assign done1          = done1_q;
    assign tx_timeout     = tmo_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with a behavioural uart_tx model (154-cycle frame).
module tb_uart_tx_sched;

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_parity = 1'b0, req1_parity = 1'b0;
  logic       req0_ready, req1_ready;
  logic       tx_start, tx_parity_type, tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       done0, done1, tx_timeout, busy, grant_id;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor logs and scoreboard expected queue
  int         start_cyc_q[$];
  logic [9:0] start_rec_q[$];
  int         done0_q[$], done1_q[$], tmo_q[$];
  logic [9:0] exp_q[$];

  // uart_tx model state
  logic model_en = 1'b1;
  bit   m_active = 1'b0;
  int   m_left = 0;
  int   inject_cnt = 0, inject_seen = 0;

  uart_tx_sched #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk_3125(clk_3125), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_parity(req0_parity), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_parity(req1_parity), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_parity_type(tx_parity_type), .tx_done(tx_done),
    .done0(done0), .done1(done1), .tx_timeout(tx_timeout), .busy(busy), .grant_id(grant_id),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_3125 = ~clk_3125;
  always @(posedge clk_3125) cyc <= cyc + 1;

  // ---------------- monitor + uart_tx model (negedge) ----------------
  always @(negedge clk_3125) begin
    if (tx_start) begin
      start_cyc_q.push_back(cyc);
      start_rec_q.push_back({grant_id, tx_parity_type, tx_data});
    end
    if (done0) done0_q.push_back(cyc);
    if (done1) done1_q.push_back(cyc);
    if (tx_timeout) tmo_q.push_back(cyc);
    if (tx_done) tx_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_left = 0;
    end else begin
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          tx_done = 1'b1;
          m_active = 1'b0;
        end
      end
      if (inject_cnt != inject_seen) begin
        tx_done = 1'b1;
        inject_seen = inject_cnt;
      end
      if (tx_start && model_en) begin
        m_active = 1'b1;
        m_left = 154;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_3125);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input int who, input logic [7:0] d, input logic p, output int pc);
    int k = 0;
    tick();
    if (who == 0) begin req0_valid = 1'b1; req0_data = d; req0_parity = p; end
    else begin req1_valid = 1'b1; req1_data = d; req1_parity = p; end
    while (((who == 0) ? !req0_ready : !req1_ready) && k < 600) begin
      tick();
      k++;
    end
    pc = cyc;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic push_both(input logic [7:0] d0, input logic p0,
                           input logic [7:0] d1, input logic p1, output int pc);
    tick();
    req0_valid = 1'b1; req0_data = d0; req0_parity = p0;
    req1_valid = 1'b1; req1_data = d1; req1_parity = p1;
    pc = cyc;
    checks++;
    if (!(req0_ready && req1_ready)) begin
      errors++;
      $display("FAIL push_both_ready: got r0=%0b r1=%0b expected 1 1", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Bounded wait for n logged starts and the scheduler back in IDLE.
  task automatic wait_idle(input int n, input int budget);
    int k = 0;
    while (!(start_cyc_q.size() >= n && !busy) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_idle: got %0d starts busy=%0b expected %0d starts idle", start_cyc_q.size(), busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, tx_start, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in: got ready0/1,start,busy=%b expected 0000", {req0_ready, req1_ready, tx_start, busy});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_data, tx_parity_type, grant_id, done0, done1, tx_timeout, busy, tx_start} !== 15'h0) begin
      errors++;
      $display("FAIL reset_out: got data=%h par=%b gid=%b d0=%b d1=%b tmo=%b busy=%b start=%b expected all 0",
               tx_data, tx_parity_type, grant_id, done0, done1, tx_timeout, busy, tx_start);
    end
    checks++;
    if ({req0_ready, req1_ready, fsm_state} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ready_state: got %b expected 1100", {req0_ready, req1_ready, fsm_state});
    end
  endtask

  task automatic test_single_byte();
    int sb, d0b, d1b, pc;
    apply_reset();
    model_en = 1'b1;
    sb = start_cyc_q.size(); d0b = done0_q.size(); d1b = done1_q.size();
    push_one(0, 8'hA5, 1'b0, pc);
    wait_idle(sb + 1, 400);
    checks++;
    if (start_cyc_q[sb] !== pc + 2) begin
      errors++;
      $display("FAIL single_latency: got start cycle %0d expected %0d", start_cyc_q[sb], pc + 2);
    end
    checks++;
    if (start_rec_q[sb] !== 10'h0A5) begin
      errors++;
      $display("FAIL single_rec: got %h expected 0a5", start_rec_q[sb]);
    end
    checks++;
    if (done0_q.size() != d0b + 1 || done0_q[d0b] !== pc + 2 + 155) begin
      errors++;
      $display("FAIL single_done0: got n=%0d cyc=%0d expected one at %0d", done0_q.size() - d0b, done0_q[d0b], pc + 157);
    end
    checks++;
    if (done1_q.size() != d1b) begin
      errors++;
      $display("FAIL single_done1: got %0d pulses expected 0", done1_q.size() - d1b);
    end
  endtask

  task automatic test_tie_order();
    int sb, pc, pd;
    apply_reset();
    model_en = 1'b1;
    sb = start_cyc_q.size();
    push_both(8'h11, 1'b0, 8'h21, 1'b0, pc);
    push_both(8'h12, 1'b1, 8'h22, 1'b1, pd);
    push_both(8'h13, 1'b0, 8'h23, 1'b0, pd);
    wait_idle(sb + 6, 1500);
    exp_q = {10'h011, 10'h221, 10'h112, 10'h322, 10'h013, 10'h223};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (start_rec_q[sb + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL tie_order[%0d]: got %h expected %h", i, start_rec_q[sb + i], exp_q[i]);
      end
    end
    checks++;
    if (start_cyc_q[sb] !== pc + 2) begin
      errors++;
      $display("FAIL tie_first_start: got %0d expected %0d", start_cyc_q[sb], pc + 2);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (start_cyc_q[sb + i] - start_cyc_q[sb + i - 1] !== 156) begin
        errors++;
        $display("FAIL tie_gap[%0d]: got %0d expected 156", i, start_cyc_q[sb + i] - start_cyc_q[sb + i - 1]);
      end
    end
  endtask

  task automatic test_full();
    int sb, tb0, d1b, pc0, pd, s0, k, rc;
    apply_reset();
    model_en = 1'b0;
    sb = start_cyc_q.size(); tb0 = tmo_q.size(); d1b = done1_q.size();
    push_one(0, 8'hF0, 1'b0, pc0);
    s0 = pc0 + 2;
    push_one(1, 8'h31, 1'b1, pd);
    push_one(1, 8'h32, 1'b0, pd);
    push_one(1, 8'h33, 1'b1, pd);
    push_one(1, 8'h34, 1'b0, pd);
    tick();
    req1_valid = 1'b1; req1_data = 8'h35; req1_parity = 1'b1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low: got %b expected 0", req1_ready);
    end
    k = 0;
    while (!req1_ready && k < 400) begin
      tick();
      k++;
    end
    rc = cyc;
    tick();
    req1_valid = 1'b0;
    model_en = 1'b1;
    checks++;
    if (rc !== s0 + 257) begin
      errors++;
      $display("FAIL full_ready_rise: got cycle %0d expected %0d", rc, s0 + 257);
    end
    wait_idle(sb + 6, 3000);
    exp_q = {10'h0F0, 10'h331, 10'h232, 10'h333, 10'h234, 10'h335};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (start_rec_q[sb + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_order[%0d]: got %h expected %h", i, start_rec_q[sb + i], exp_q[i]);
      end
    end
    checks++;
    if (start_cyc_q.size() - sb != 6 || tmo_q.size() - tb0 != 2 || done1_q.size() - d1b != 4) begin
      errors++;
      $display("FAIL full_counts: got starts=%0d tmo=%0d done1=%0d expected 6 2 4",
               start_cyc_q.size() - sb, tmo_q.size() - tb0, done1_q.size() - d1b);
    end
  endtask

  task automatic test_mixed_parity();
    int sb, d0b, d1b, pc;
    apply_reset();
    model_en = 1'b1;
    sb = start_cyc_q.size(); d0b = done0_q.size(); d1b = done1_q.size();
    push_both(8'h3C, 1'b1, 8'h3C, 1'b0, pc);
    wait_idle(sb + 2, 700);
    exp_q = {10'h13C, 10'h23C};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (start_rec_q[sb + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mixed_parity[%0d]: got %h expected %h", i, start_rec_q[sb + i], exp_q[i]);
      end
    end
    checks++;
    if (done0_q[d0b] !== start_cyc_q[sb] + 155 || done1_q[d1b] !== start_cyc_q[sb + 1] + 155) begin
      errors++;
      $display("FAIL mixed_done: got d0=%0d d1=%0d expected %0d %0d", done0_q[d0b], done1_q[d1b],
               start_cyc_q[sb] + 155, start_cyc_q[sb + 1] + 155);
    end
  endtask

  task automatic test_timeout();
    int sb, tb0, d0b, d1b, pc, s0;
    apply_reset();
    model_en = 1'b0;
    sb = start_cyc_q.size(); tb0 = tmo_q.size(); d0b = done0_q.size(); d1b = done1_q.size();
    push_both(8'h55, 1'b0, 8'h66, 1'b1, pc);
    s0 = pc + 2;
    wait_idle(sb + 2, 1200);
    checks++;
    if (tmo_q[tb0] !== s0 + 256) begin
      errors++;
      $display("FAIL timeout_first: got %0d expected %0d", tmo_q[tb0], s0 + 256);
    end
    checks++;
    if (start_cyc_q[sb + 1] !== s0 + 257 || start_rec_q[sb + 1] !== 10'h366) begin
      errors++;
      $display("FAIL timeout_next_start: got cyc=%0d rec=%h expected %0d 366", start_cyc_q[sb + 1], start_rec_q[sb + 1], s0 + 257);
    end
    checks++;
    if (tmo_q[tb0 + 1] !== s0 + 513) begin
      errors++;
      $display("FAIL timeout_second: got %0d expected %0d", tmo_q[tb0 + 1], s0 + 513);
    end
    inject_cnt++;
    repeat (5) tick();
    checks++;
    if (done0_q.size() != d0b || done1_q.size() != d1b || busy !== 1'b0 || start_cyc_q.size() != sb + 2) begin
      errors++;
      $display("FAIL timeout_late_done: got d0=%0d d1=%0d busy=%b starts=%0d expected 0 0 0 2",
               done0_q.size() - d0b, done1_q.size() - d1b, busy, start_cyc_q.size() - sb);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int sb, pc, pd, s, k, rb, d0b, d1b, tb0;
    apply_reset();
    model_en = 1'b1;
    sb = start_cyc_q.size();
    push_one(0, 8'h77, 1'b0, pc);
    s = pc + 2;
    push_both(8'h78, 1'b0, 8'h79, 1'b1, pd);
    k = 0;
    while (cyc < s + 70 && k < 200) begin
      tick();
      k++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, tx_data, tx_parity_type, done0, done1, tx_timeout, busy, grant_id, req0_ready, req1_ready} !== 17'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got start=%b data=%h par=%b d0=%b d1=%b tmo=%b busy=%b gid=%b r0=%b r1=%b expected all 0",
               tx_start, tx_data, tx_parity_type, done0, done1, tx_timeout, busy, grant_id, req0_ready, req1_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    rb = start_cyc_q.size(); d0b = done0_q.size(); d1b = done1_q.size(); tb0 = tmo_q.size();
    repeat (400) tick();
    checks++;
    if (start_cyc_q.size() != rb || done0_q.size() != d0b || done1_q.size() != d1b || tmo_q.size() != tb0) begin
      errors++;
      $display("FAIL midreset_quiet: got starts=%0d d0=%0d d1=%0d tmo=%0d expected 0 0 0 0",
               start_cyc_q.size() - rb, done0_q.size() - d0b, done1_q.size() - d1b, tmo_q.size() - tb0);
    end
    push_one(1, 8'h7A, 1'b1, pc);
    wait_idle(rb + 1, 400);
    checks++;
    if (start_cyc_q[rb] !== pc + 2 || start_rec_q[rb] !== 10'h37A) begin
      errors++;
      $display("FAIL midreset_new_push: got cyc=%0d rec=%h expected %0d 37a", start_cyc_q[rb], start_rec_q[rb], pc + 2);
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_tie_order();
    test_full();
    test_mixed_parity();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
